ysyx_25040105_lsu: RTL and testbench

- Multi-cycle load/store unit directly downstream of the EXU.
- Takes the effective address, access size, signedness and store data from the EXU, and runs one transaction on a valid/ready memory bus.
- Returns aligned, sign- or zero-extended load data, or store completion, to writeback over a valid/ready handshake.
- Flags misaligned accesses, bus errors and response timeouts.

---
 rtl/ysyx_25040105_lsu.sv | 195 +++++++++++++++++++
 tb/tb_ysyx_25040105_lsu.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25040105_lsu.sv
// Load/store unit sitting after the EXU: runs one valid/ready bus transaction per op,
// aligns store lanes, extracts and extends load data, and flags misalignment/bus errors/timeouts.
module ysyx_25040105_lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_wen,
    input  logic [1:0]  in_size,
    input  logic        in_unsigned,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_rsp_valid,
    input  logic        mem_rsp_err,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic        out_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam logic [7:0] TIMEOUT_L = TIMEOUT[7:0];

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic        wen_q, wen_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        bad_op_s;

    function automatic logic [3:0] lane_strb(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'd0:    return 4'b0001 << off;
            2'd1:    return 4'b0011 << off;
            2'd2:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] data);
        case (size)
            2'd0:    return {4{data[7:0]}};
            2'd1:    return {2{data[15:0]}};
            2'd2:    return data;
            default: return 32'h0000_0000;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [1:0] size, input logic uns,
                                                 input logic [1:0] off, input logic [31:0] raw);
        logic [31:0] sh;
        sh = raw >> {off, 3'b000};
        case (size)
            2'd0:    return {{24{sh[7] & ~uns}}, sh[7:0]};
            2'd1:    return {{16{sh[15] & ~uns}}, sh[15:0]};
            2'd2:    return sh;
            default: return 32'h0000_0000;
        endcase
    endfunction

    // Illegal size or an address not aligned to the access size never reaches the bus.
    always_comb begin
        bad_op_s = 1'b0;
        case (in_size)
            2'd0:    bad_op_s = 1'b0;
            2'd1:    bad_op_s = in_addr[0];
            2'd2:    bad_op_s = (in_addr[1:0] != 2'b00);
            default: bad_op_s = 1'b1;
        endcase
    end

    // Next-state and datapath register updates for the IDLE/REQ/WAIT/DONE sequence.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        uns_d   = uns_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    addr_d  = in_addr;
                    size_d  = in_size;
                    uns_d   = in_unsigned;
                    wen_d   = in_wen;
                    wdata_d = lane_wdata(in_size, in_wdata);
                    wstrb_d = in_wen ? lane_strb(in_size, in_addr[1:0]) : 4'b0000;
                    rdata_d = 32'h0000_0000;
                    cnt_d   = 8'd0;
                    err_d   = bad_op_s;
                    state_d = bad_op_s ? S_DONE : S_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    state_d = S_WAIT;
                    cnt_d   = 8'd0;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                // A response in the timeout cycle takes priority over the timeout.
                if (mem_rsp_valid) begin
                    state_d = S_DONE;
                    err_d   = mem_rsp_err;
                    rdata_d = (mem_rsp_err || wen_q) ? 32'h0000_0000
                                                     : load_extract(size_q, uns_q, addr_q[1:0], mem_rdata);
                end else if ((cnt_q + 8'd1) == TIMEOUT_L) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                    rdata_d = 32'h0000_0000;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and captured-op registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= 32'h0000_0000;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            wen_q   <= 1'b0;
            wdata_q <= 32'h0000_0000;
            wstrb_q <= 4'b0000;
            cnt_q   <= 8'd0;
            rdata_q <= 32'h0000_0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign in_ready      = (state_q == S_IDLE);
    assign mem_req_valid = (state_q == S_REQ);
    assign mem_we        = wen_q;
    assign mem_addr      = {addr_q[31:2], 2'b00};
    assign mem_wdata     = wdata_q;
    assign mem_wstrb     = wstrb_q;
    assign out_valid     = (state_q == S_DONE);
    assign out_rdata     = rdata_q;
    assign out_err       = err_q;

endmodule

// File: tb/tb_ysyx_25040105_lsu.sv
// Directed self-checking bench for the LSU: lane mapping, extension, misalignment,
// backpressure, timeout and asynchronous reset mid-transaction.
module tb_ysyx_25040105_lsu;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_wen;
    logic [1:0]  in_size;
    logic        in_unsigned;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rsp_valid;
    logic        mem_rsp_err;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rdata;
    logic        out_err;

    int checks_r;
    int failures_r;

    ysyx_25040105_lsu #(.TIMEOUT(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_wen        (in_wen),
        .in_size       (in_size),
        .in_unsigned   (in_unsigned),
        .in_addr       (in_addr),
        .in_wdata      (in_wdata),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wstrb     (mem_wstrb),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_err   (mem_rsp_err),
        .mem_rdata     (mem_rdata),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_rdata     (out_rdata),
        .out_err       (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_r++;
        if (got !== exp) begin
            failures_r++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Presents one op for a single cycle; returns at the negedge of cycle T+1.
    task automatic issue(input logic wen, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        chk("issue_in_ready", {31'd0, in_ready}, 32'd1);
        in_wen      = wen;
        in_size     = size;
        in_unsigned = uns;
        in_addr     = addr;
        in_wdata    = wdata;
        in_valid    = 1'b1;
        @(negedge clk);
        in_valid    = 1'b0;
    endtask

    // Full transaction with immediate request ready and next-cycle response.
    task automatic do_txn(input string tag, input logic wen, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input logic rerr,
                          input logic [31:0] e_addr, input logic [3:0] e_strb,
                          input logic [31:0] e_wdata, input logic [31:0] e_rdata, input logic e_err);
        issue(wen, size, uns, addr, wdata);
        chk({tag, ":req_valid"}, {31'd0, mem_req_valid}, 32'd1);
        chk({tag, ":addr"}, mem_addr, e_addr);
        chk({tag, ":we"}, {31'd0, mem_we}, {31'd0, wen});
        chk({tag, ":wstrb"}, {28'd0, mem_wstrb}, {28'd0, e_strb});
        if (wen) chk({tag, ":wdata"}, mem_wdata, e_wdata);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk({tag, ":req_drop"}, {31'd0, mem_req_valid}, 32'd0);
        chk({tag, ":early_out"}, {31'd0, out_valid}, 32'd0);
        mem_rsp_valid = 1'b1;
        mem_rsp_err   = rerr;
        mem_rdata     = rdata;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        mem_rsp_err   = 1'b0;
        chk({tag, ":out_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, ":rdata"}, out_rdata, e_rdata);
        chk({tag, ":err"}, {31'd0, out_err}, {31'd0, e_err});
        chk({tag, ":busy"}, {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, ":out_drop"}, {31'd0, out_valid}, 32'd0);
        chk({tag, ":ready_back"}, {31'd0, in_ready}, 32'd1);
    endtask

    // Misaligned or illegal-size op: no bus request, error result the next cycle.
    task automatic do_bad(input string tag, input logic [1:0] size, input logic [31:0] addr);
        issue(1'b0, size, 1'b0, addr, 32'h0000_0000);
        chk({tag, ":no_req"}, {31'd0, mem_req_valid}, 32'd0);
        chk({tag, ":out_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, ":err"}, {31'd0, out_err}, 32'd1);
        chk({tag, ":rdata"}, out_rdata, 32'h0000_0000);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, ":no_req2"}, {31'd0, mem_req_valid}, 32'd0);
        chk({tag, ":ready_back"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        checks_r      = 0;
        failures_r    = 0;
        rst_n         = 1'b0;
        in_valid      = 1'b0;
        in_wen        = 1'b0;
        in_size       = 2'd0;
        in_unsigned   = 1'b0;
        in_addr       = 32'h0000_0000;
        in_wdata      = 32'h0000_0000;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_err   = 1'b0;
        mem_rdata     = 32'h0000_0000;
        out_ready     = 1'b0;

        #2;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_addr", mem_addr, 32'h0000_0000);
        chk("rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
        chk("rst_rdata", out_rdata, 32'h0000_0000);
        chk("rst_err", {31'd0, out_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        //     tag      wen   size  uns   addr           wdata          rdata          rerr  e_addr         e_strb   e_wdata        e_rdata        e_err
        do_txn("lb",    1'b0, 2'd0, 1'b0, 32'h8000_0003, 32'h0,         32'h8011_2233, 1'b0, 32'h8000_0000, 4'b0000, 32'h0,         32'hFFFF_FF80, 1'b0);
        do_txn("lbu",   1'b0, 2'd0, 1'b1, 32'h8000_0003, 32'h0,         32'h8011_2233, 1'b0, 32'h8000_0000, 4'b0000, 32'h0,         32'h0000_0080, 1'b0);
        do_txn("sh",    1'b1, 2'd1, 1'b0, 32'h8000_0102, 32'h1234_ABCD, 32'h5555_5555, 1'b0, 32'h8000_0100, 4'b1100, 32'hABCD_ABCD, 32'h0000_0000, 1'b0);
        do_txn("lh",    1'b0, 2'd1, 1'b0, 32'h8000_0002, 32'h0,         32'h8001_7FFF, 1'b0, 32'h8000_0000, 4'b0000, 32'h0,         32'hFFFF_8001, 1'b0);
        do_txn("lhu",   1'b0, 2'd1, 1'b1, 32'h8000_0002, 32'h0,         32'h8001_7FFF, 1'b0, 32'h8000_0000, 4'b0000, 32'h0,         32'h0000_8001, 1'b0);
        do_txn("lb0",   1'b0, 2'd0, 1'b0, 32'h8000_0010, 32'h0,         32'h1122_337F, 1'b0, 32'h8000_0010, 4'b0000, 32'h0,         32'h0000_007F, 1'b0);
        do_txn("sb",    1'b1, 2'd0, 1'b0, 32'h8000_0001, 32'h0000_00A5, 32'h0,         1'b0, 32'h8000_0000, 4'b0010, 32'hA5A5_A5A5, 32'h0000_0000, 1'b0);
        do_txn("sw",    1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'h1234_5678, 32'h0,         1'b0, 32'h0000_0010, 4'b1111, 32'h1234_5678, 32'h0000_0000, 1'b0);
        do_txn("lwerr", 1'b0, 2'd2, 1'b0, 32'h8000_0020, 32'h0,         32'hFFFF_FFFF, 1'b1, 32'h8000_0020, 4'b0000, 32'h0,         32'h0000_0000, 1'b1);

        do_bad("mis_lw", 2'd2, 32'h8000_0001);
        do_bad("mis_lh", 2'd1, 32'h8000_0003);
        do_bad("size3",  2'd3, 32'h8000_0000);

        // Backpressure on both the request and the result side.
        issue(1'b0, 2'd2, 1'b0, 32'h8000_0204, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk("bp_req_valid", {31'd0, mem_req_valid}, 32'd1);
            chk("bp_addr", mem_addr, 32'h8000_0204);
            chk("bp_we", {31'd0, mem_we}, 32'd0);
            chk("bp_wstrb", {28'd0, mem_wstrb}, 32'd0);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end
        chk("bp_req_valid4", {31'd0, mem_req_valid}, 32'd1);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'h1122_3344;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_rdata", out_rdata, 32'h1122_3344);
            chk("bp_err", {31'd0, out_err}, 32'd0);
            chk("bp_busy", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end
        chk("bp_out_valid3", {31'd0, out_valid}, 32'd1);
        chk("bp_busy3", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_ready_back", {31'd0, in_ready}, 32'd1);

        // Timeout after four silent WAIT cycles.
        issue(1'b0, 2'd2, 1'b0, 32'h8000_0008, 32'h0);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("to_wait", {31'd0, out_valid}, 32'd0);
            @(negedge clk);
        end
        chk("to_out_valid", {31'd0, out_valid}, 32'd1);
        chk("to_err", {31'd0, out_err}, 32'd1);
        chk("to_rdata", out_rdata, 32'h0000_0000);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        // Stray response while idle must be ignored.
        mem_rsp_valid = 1'b1;
        mem_rsp_err   = 1'b1;
        mem_rdata     = 32'h5A5A_5A5A;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        mem_rsp_err   = 1'b0;
        chk("stray_out_valid", {31'd0, out_valid}, 32'd0);
        chk("stray_in_ready", {31'd0, in_ready}, 32'd1);
        chk("stray_req", {31'd0, mem_req_valid}, 32'd0);
        do_txn("post_to", 1'b0, 2'd2, 1'b0, 32'h8000_0000, 32'h0, 32'hDEAD_BEEF, 1'b0,
               32'h8000_0000, 4'b0000, 32'h0, 32'hDEAD_BEEF, 1'b0);

        // Response in the same cycle as the timeout wins.
        issue(1'b0, 2'd2, 1'b0, 32'h8000_000C, 32'h0);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("race_wait", {31'd0, out_valid}, 32'd0);
            @(negedge clk);
        end
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'h0BAD_F00D;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        chk("race_out_valid", {31'd0, out_valid}, 32'd1);
        chk("race_err", {31'd0, out_err}, 32'd0);
        chk("race_rdata", out_rdata, 32'h0BAD_F00D);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Asynchronous reset while waiting for a response.
        issue(1'b1, 2'd2, 1'b0, 32'h8000_0040, 32'hFFFF_FFFF);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk("rmid_in_wait", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rmid_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rmid_req", {31'd0, mem_req_valid}, 32'd0);
        chk("rmid_we", {31'd0, mem_we}, 32'd0);
        chk("rmid_addr", mem_addr, 32'h0000_0000);
        chk("rmid_wdata", mem_wdata, 32'h0000_0000);
        chk("rmid_wstrb", {28'd0, mem_wstrb}, 32'd0);
        chk("rmid_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rmid_rdata", out_rdata, 32'h0000_0000);
        chk("rmid_err", {31'd0, out_err}, 32'd0);
        @(negedge clk);
        rst_n         = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'h1234_5678;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        chk("rmid_stray_out", {31'd0, out_valid}, 32'd0);
        chk("rmid_stray_rdy", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        chk("rmid_stray_out2", {31'd0, out_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
        $finish;
    end

endmodule
